graph_vertex_fetcher: RTL and testbench

Parametrised vertex-record fetch engine for the graph pipeline. It takes a vertex base address and reads that vertex's DIM-word position vector on memory port A. In parallel it reads the zero-terminated neighbour list on memory port B. It buffers both streams in internal FIFOs for the downstream force/update stages. Over the previous fetch unit it adds configurable widths and FIFO depths, credit-based backpressure, an explicit busy/done handshake, a neighbour degree count and an optional degree cap.

---
 rtl/graph_vertex_fetcher.sv | 240 ++++++++++++++++++++++++
 tb/tb_graph_vertex_fetcher.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_vertex_fetcher.sv
// graph_vertex_fetcher: fetches one vertex record for the graph pipeline.
//   Port A reads the DIM-word position vector at base+1 .. base+DIM.
//   Port B reads the zero-terminated neighbour list starting at base+1+DIM.
//   Both streams are buffered in internal FIFOs, with credit-based request issue.
// Optional feature: define GRAPH_FETCH_DEG_LIMIT_EN to cap the neighbour count at MAX_DEG.
// Ports:
//   clk_in, rst_in                : clock, synchronous active-high reset
//   v_addr_in, valid_in, ready_out: start handshake (accepted in idle only)
//   done_out, deg_out, trunc_out  : completion pulse, degree count, degree-cap flag
//   pos_*   / neigh_*             : FIFO pop strobe, head data and status
//   mem_a_* / mem_b_*             : single-outstanding read ports (request/response)
module graph_vertex_fetcher #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DIM         = 2,
  parameter int unsigned POS_DEPTH   = DIM,
  parameter int unsigned NEIGH_DEPTH = 4,
  parameter int unsigned DEG_W       = 16,
  parameter int unsigned MAX_DEG     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] v_addr_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              done_out,
  output logic [DEG_W-1:0]  deg_out,
  output logic              trunc_out,
  input  logic              pos_deq_in,
  output logic [DATA_W-1:0] pos_data_out,
  output logic              pos_valid_out,
  output logic              pos_full_out,
  output logic              pos_empty_out,
  input  logic              neigh_deq_in,
  output logic [DATA_W-1:0] neigh_data_out,
  output logic              neigh_valid_out,
  output logic              neigh_full_out,
  output logic              neigh_empty_out,
  output logic              mem_a_req_out,
  output logic [ADDR_W-1:0] mem_a_addr_out,
  input  logic              mem_a_valid_in,
  input  logic [DATA_W-1:0] mem_a_data_in,
  output logic              mem_b_req_out,
  output logic [ADDR_W-1:0] mem_b_addr_out,
  input  logic              mem_b_valid_in,
  input  logic [DATA_W-1:0] mem_b_data_in
);

  localparam int unsigned PosPtrW = (POS_DEPTH > 1) ? $clog2(POS_DEPTH) : 1;
  localparam int unsigned PosCntW = $clog2(POS_DEPTH + 1);
  localparam int unsigned NbPtrW  = (NEIGH_DEPTH > 1) ? $clog2(NEIGH_DEPTH) : 1;
  localparam int unsigned NbCntW  = $clog2(NEIGH_DEPTH + 1);
  localparam int unsigned PlW     = $clog2(DIM + 1);

  localparam logic [PosCntW-1:0] PosDepthC = PosCntW'(POS_DEPTH);
  localparam logic [NbCntW-1:0]  NbDepthC  = NbCntW'(NEIGH_DEPTH);
  localparam logic [PosPtrW-1:0] PosLastC  = PosPtrW'(POS_DEPTH - 1);
  localparam logic [NbPtrW-1:0]  NbLastC   = NbPtrW'(NEIGH_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [PlW-1:0]      pos_left_q, pos_left_d;
  logic [ADDR_W-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_W-1:0]   a_req_addr_q, a_req_addr_d, b_req_addr_q, b_req_addr_d;
  logic                a_req_q, a_req_d, b_req_q, b_req_d;
  logic                a_out_q, a_out_d, b_out_q, b_out_d;
  logic                b_fin_q, b_fin_d;  // neighbour side finished (zero word or cap)
  logic [DEG_W-1:0]    deg_q, deg_d;
  logic                trunc_q, trunc_d;

  logic [DATA_W-1:0]   pos_mem [POS_DEPTH];
  logic [PosPtrW-1:0]  pos_wr_q, pos_rd_q;
  logic [PosCntW-1:0]  pos_cnt_q, pos_cnt_d;
  logic                pos_enq, pos_deq;
  logic [DATA_W-1:0]   nb_mem [NEIGH_DEPTH];
  logic [NbPtrW-1:0]   nb_wr_q, nb_rd_q;
  logic [NbCntW-1:0]   nb_cnt_q, nb_cnt_d;
  logic                nb_enq, nb_deq;

  always_comb begin
    state_d      = state_q;
    pos_left_d   = pos_left_q;
    a_addr_d     = a_addr_q;
    b_addr_d     = b_addr_q;
    a_req_addr_d = a_req_addr_q;
    b_req_addr_d = b_req_addr_q;
    a_req_d      = 1'b0;
    b_req_d      = 1'b0;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    b_fin_d      = b_fin_q;
    deg_d        = deg_q;
    trunc_d      = trunc_q;
    pos_enq      = 1'b0;
    nb_enq       = 1'b0;
    pos_deq      = pos_deq_in && (pos_cnt_q != '0);
    nb_deq       = neigh_deq_in && (nb_cnt_q != '0);

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          state_d    = StBusy;
          pos_left_d = PlW'(DIM);
          a_addr_d   = v_addr_in + ADDR_W'(1);
          b_addr_d   = v_addr_in + ADDR_W'(1) + ADDR_W'(DIM);
          deg_d      = '0;
          trunc_d    = 1'b0;
          b_fin_d    = 1'b0;
          a_out_d    = 1'b0;
          b_out_d    = 1'b0;
        end
      end
      StBusy: begin
        // Responses only count while a read is outstanding; anything else is stale.
        if (mem_a_valid_in && a_out_q) begin
          a_out_d    = 1'b0;
          pos_enq    = 1'b1;
          pos_left_d = pos_left_q - 1'b1;
          a_addr_d   = a_addr_q + ADDR_W'(1);
        end
        if (mem_b_valid_in && b_out_q) begin
          b_out_d = 1'b0;
          if (mem_b_data_in != '0) begin
            nb_enq   = 1'b1;
            b_addr_d = b_addr_q + ADDR_W'(1);
            if (deg_q != '1) deg_d = deg_q + DEG_W'(1);
          end else begin
            b_fin_d = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef GRAPH_FETCH_DEG_LIMIT_EN
    if (state_q == StBusy && !b_fin_d && deg_d >= DEG_W'(MAX_DEG)) begin
      b_fin_d = 1'b1;
      trunc_d = 1'b1;
    end
`endif

    // Decide on next-cycle values so a finishing response moves straight to done.
    if (state_q == StBusy && pos_left_d == '0 && b_fin_d) state_d = StDone;

    pos_cnt_d = pos_cnt_q + PosCntW'(pos_enq) - PosCntW'(pos_deq);
    nb_cnt_d  = nb_cnt_q + NbCntW'(nb_enq) - NbCntW'(nb_deq);

    // Credit check on post-update occupancy: with one read in flight the FIFO can't overflow.
    if (state_d == StBusy) begin
      if (pos_left_d != '0 && !a_out_d && pos_cnt_d < PosDepthC) begin
        a_req_d      = 1'b1;
        a_out_d      = 1'b1;
        a_req_addr_d = a_addr_d;
      end
      if (!b_fin_d && !b_out_d && nb_cnt_d < NbDepthC) begin
        b_req_d      = 1'b1;
        b_out_d      = 1'b1;
        b_req_addr_d = b_addr_d;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      pos_left_q   <= '0;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      a_req_addr_q <= '0;
      b_req_addr_q <= '0;
      a_req_q      <= 1'b0;
      b_req_q      <= 1'b0;
      a_out_q      <= 1'b0;
      b_out_q      <= 1'b0;
      b_fin_q      <= 1'b0;
      deg_q        <= '0;
      trunc_q      <= 1'b0;
      pos_wr_q     <= '0;
      pos_rd_q     <= '0;
      pos_cnt_q    <= '0;
      nb_wr_q      <= '0;
      nb_rd_q      <= '0;
      nb_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      pos_left_q   <= pos_left_d;
      a_addr_q     <= a_addr_d;
      b_addr_q     <= b_addr_d;
      a_req_addr_q <= a_req_addr_d;
      b_req_addr_q <= b_req_addr_d;
      a_req_q      <= a_req_d;
      b_req_q      <= b_req_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      b_fin_q      <= b_fin_d;
      deg_q        <= deg_d;
      trunc_q      <= trunc_d;
      pos_cnt_q    <= pos_cnt_d;
      nb_cnt_q     <= nb_cnt_d;
      if (pos_enq) pos_wr_q <= (pos_wr_q == PosLastC) ? '0 : pos_wr_q + 1'b1;
      if (pos_deq) pos_rd_q <= (pos_rd_q == PosLastC) ? '0 : pos_rd_q + 1'b1;
      if (nb_enq)  nb_wr_q  <= (nb_wr_q == NbLastC) ? '0 : nb_wr_q + 1'b1;
      if (nb_deq)  nb_rd_q  <= (nb_rd_q == NbLastC) ? '0 : nb_rd_q + 1'b1;
    end
  end

  // FIFO storage needs no reset; the pointers and counts define validity.
  always_ff @(posedge clk_in) begin
    if (pos_enq) pos_mem[pos_wr_q] <= mem_a_data_in;
    if (nb_enq)  nb_mem[nb_wr_q]   <= mem_b_data_in;
  end

  assign ready_out       = (state_q == StIdle);
  assign done_out        = (state_q == StDone);
  assign deg_out         = deg_q;
  assign mem_a_req_out   = a_req_q;
  assign mem_a_addr_out  = a_req_addr_q;
  assign mem_b_req_out   = b_req_q;
  assign mem_b_addr_out  = b_req_addr_q;
  assign pos_data_out    = pos_mem[pos_rd_q];
  assign pos_valid_out   = (pos_cnt_q != '0);
  assign pos_empty_out   = (pos_cnt_q == '0);
  assign pos_full_out    = (pos_cnt_q == PosDepthC);
  assign neigh_data_out  = nb_mem[nb_rd_q];
  assign neigh_valid_out = (nb_cnt_q != '0);
  assign neigh_empty_out = (nb_cnt_q == '0);
  assign neigh_full_out  = (nb_cnt_q == NbDepthC);

`ifdef GRAPH_FETCH_DEG_LIMIT_EN
  assign trunc_out = trunc_q;
`else
  // Without the degree cap trunc_q never leaves zero and MAX_DEG has no effect.
  logic unused_max_deg;
  assign unused_max_deg = ^MAX_DEG ^ trunc_q;
  assign trunc_out      = 1'b0;
`endif

endmodule

// File: tb/tb_graph_vertex_fetcher.sv
// Self-checking bench for graph_vertex_fetcher: memory responders with optional random
// latency, random FIFO pops, and a reference model that walks the record in memory.
module tb_graph_vertex_fetcher;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned DIM = 2;
  localparam int unsigned MAX_DEG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in = 1'b1;
  logic [AW-1:0] v_addr_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out, done_out, trunc_out;
  logic [15:0]   deg_out;
  logic          pos_deq_in = 1'b0, neigh_deq_in = 1'b0;
  logic [DW-1:0] pos_data_out, neigh_data_out;
  logic          pos_valid_out, pos_full_out, pos_empty_out;
  logic          neigh_valid_out, neigh_full_out, neigh_empty_out;
  logic          mem_a_req_out, mem_b_req_out;
  logic [AW-1:0] mem_a_addr_out, mem_b_addr_out;
  logic          mem_a_valid_in = 1'b0, mem_b_valid_in = 1'b0;
  logic [DW-1:0] mem_a_data_in = '0, mem_b_data_in = '0;

  graph_vertex_fetcher #(
    .DATA_W(DW), .ADDR_W(AW), .DIM(DIM), .POS_DEPTH(2), .NEIGH_DEPTH(2), .DEG_W(16),
    .MAX_DEG(MAX_DEG)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .v_addr_in(v_addr_in), .valid_in(valid_in),
    .ready_out(ready_out), .done_out(done_out), .deg_out(deg_out), .trunc_out(trunc_out),
    .pos_deq_in(pos_deq_in), .pos_data_out(pos_data_out), .pos_valid_out(pos_valid_out),
    .pos_full_out(pos_full_out), .pos_empty_out(pos_empty_out),
    .neigh_deq_in(neigh_deq_in), .neigh_data_out(neigh_data_out),
    .neigh_valid_out(neigh_valid_out), .neigh_full_out(neigh_full_out),
    .neigh_empty_out(neigh_empty_out),
    .mem_a_req_out(mem_a_req_out), .mem_a_addr_out(mem_a_addr_out),
    .mem_a_valid_in(mem_a_valid_in), .mem_a_data_in(mem_a_data_in),
    .mem_b_req_out(mem_b_req_out), .mem_b_addr_out(mem_b_addr_out),
    .mem_b_valid_in(mem_b_valid_in), .mem_b_data_in(mem_b_data_in)
  );

  logic [DW-1:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int pos_mode = 1, neigh_mode = 1;  // 0 hold low, 1 hold high, 2 random
  bit rand_lat = 1'b0, inj = 1'b0;
  logic [DW-1:0] pos_got[$], neigh_got[$];
  logic [AW-1:0] a_addrs[$], b_addrs[$];
  int done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int a_cnt = 0, b_cnt = 0;
  logic [AW-1:0] a_pend = '0, b_pend = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responders, FIFO poppers and observers; everything acts on the falling edge.
  initial forever begin
    @(negedge clk);
    mem_a_valid_in = 1'b0;
    mem_b_valid_in = 1'b0;
    if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin mem_a_valid_in = 1'b1; mem_a_data_in = mem[a_pend]; end
    end
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin mem_b_valid_in = 1'b1; mem_b_data_in = mem[b_pend]; end
    end
    if (inj) begin
      mem_a_valid_in = 1'b1; mem_a_data_in = 16'hBEEF;
      mem_b_valid_in = 1'b1; mem_b_data_in = 16'hBEEF;
    end
    if (mem_a_req_out) begin
      a_pend = mem_a_addr_out;
      a_cnt  = rand_lat ? int'($urandom_range(1, 3)) : 1;
      a_addrs.push_back(mem_a_addr_out);
    end
    if (mem_b_req_out) begin
      b_pend = mem_b_addr_out;
      b_cnt  = rand_lat ? int'($urandom_range(1, 3)) : 1;
      b_addrs.push_back(mem_b_addr_out);
    end
    pos_deq_in   = (pos_mode == 2) ? ($urandom_range(0, 1) == 1) : (pos_mode == 1);
    neigh_deq_in = (neigh_mode == 2) ? ($urandom_range(0, 1) == 1) : (neigh_mode == 1);
    if (!rst_in && pos_deq_in && pos_valid_out) pos_got.push_back(pos_data_out);
    if (!rst_in && neigh_deq_in && neigh_valid_out) neigh_got.push_back(neigh_data_out);
    if (done_out) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_vertex(input logic [AW-1:0] v);
    bit ok = 1'b0;
    pos_got.delete(); neigh_got.delete(); a_addrs.delete(); b_addrs.delete();
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_out) begin ok = 1'b1; break; end
    end
    chk("ready_before_accept", {31'd0, ok}, 32'd1);
    valid_in  = 1'b1;
    v_addr_in = v;
    acc_cyc   = cyc;
    @(negedge clk);
    valid_in  = 1'b0;
    v_addr_in = 8'hA5;  // garbage while busy must be ignored
  endtask

  // Reference model: walk the record straight out of memory, then compare everything seen.
  task automatic finish_vertex(input logic [AW-1:0] v, input bit timed);
    logic [DW-1:0] exp_pos[$], exp_nb[$];
    logic [DW-1:0] w;
    int reads = 0, mx;
    bit trunc = 1'b0, ok = 1'b0;
    for (int i = 0; i < DIM; i++) exp_pos.push_back(mem[8'(v + 8'd1 + 8'(i))]);
    for (int k = 0; k < 200; k++) begin
`ifdef GRAPH_FETCH_DEG_LIMIT_EN
      if (exp_nb.size() >= MAX_DEG) begin trunc = 1'b1; break; end
`endif
      w = mem[8'(v + 8'd1 + 8'(DIM) + 8'(k))];
      reads++;
      if (w == '0) break;
      exp_nb.push_back(w);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
    repeat (3) @(negedge clk);
    pos_mode = 1; neigh_mode = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pos_empty_out && neigh_empty_out) begin ok = 1'b1; break; end
    end
    chk("drain", {31'd0, ok}, 32'd1);
    chk("done_pulses", done_cnt, 1);
    chk("ready_after", {31'd0, ready_out}, 32'd1);
    chk("deg_out", {16'd0, deg_out}, exp_nb.size());
    chk("trunc_out", {31'd0, trunc_out}, {31'd0, trunc});
    chk("pos_count", pos_got.size(), exp_pos.size());
    for (int i = 0; i < exp_pos.size() && i < pos_got.size(); i++)
      chk("pos_data", {16'd0, pos_got[i]}, {16'd0, exp_pos[i]});
    chk("neigh_count", neigh_got.size(), exp_nb.size());
    for (int i = 0; i < exp_nb.size() && i < neigh_got.size(); i++)
      chk("neigh_data", {16'd0, neigh_got[i]}, {16'd0, exp_nb[i]});
    chk("a_req_count", a_addrs.size(), DIM);
    for (int i = 0; i < a_addrs.size(); i++)
      chk("a_addr", {24'd0, a_addrs[i]}, {24'd0, 8'(v + 8'd1 + 8'(i))});
    chk("b_req_count", b_addrs.size(), reads);
    for (int i = 0; i < b_addrs.size(); i++)
      chk("b_addr", {24'd0, b_addrs[i]}, {24'd0, 8'(v + 8'd1 + 8'(DIM) + 8'(i))});
    mx = (DIM > exp_nb.size() + 1) ? DIM : exp_nb.size() + 1;
    if (timed) chk("vertex_latency", done_cyc - acc_cyc, 2 * mx + 1);
  endtask

  task automatic put_list(input logic [AW-1:0] v, input logic [DW-1:0] p0,
                          input logic [DW-1:0] p1, input logic [DW-1:0] lst[$]);
    mem[8'(v + 8'd1)] = p0;
    mem[8'(v + 8'd2)] = p1;
    for (int i = 0; i < lst.size(); i++) mem[8'(v + 8'd3 + 8'(i))] = lst[i];
  endtask

  initial begin
    logic [DW-1:0] lst[$];
    logic [AW-1:0] v;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    // Reset state, sampled while reset is still applied.
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_deg", {16'd0, deg_out}, 32'd0);
    chk("rst_trunc", {31'd0, trunc_out}, 32'd0);
    chk("rst_reqs", {30'd0, mem_a_req_out, mem_b_req_out}, 32'd0);
    chk("rst_addrs", {16'd0, mem_a_addr_out, mem_b_addr_out}, 32'd0);
    chk("rst_fifo_flags", {26'd0, pos_valid_out, pos_full_out, pos_empty_out,
        neigh_valid_out, neigh_full_out, neigh_empty_out}, 32'b001001);
    rst_in = 1'b0;
    @(negedge clk);

    // Basic record, 1-cycle memory, pops always on: minimum vertex time.
    lst = '{16'd40, 16'd41, 16'd0};
    put_list(8'd10, 16'd7, 16'd9, lst);
    start_vertex(8'd10);
    finish_vertex(8'd10, 1'b1);

    // Neighbour FIFO backpressure with deq held low.
    lst = '{16'd40, 16'd41, 16'd42, 16'd0};
    put_list(8'd10, 16'd7, 16'd9, lst);
    neigh_mode = 0;
    start_vertex(8'd10);
    repeat (15) @(negedge clk);
    chk("stall_full", {31'd0, neigh_full_out}, 32'd1);
    chk("stall_b_reqs", b_addrs.size(), 2);
    chk("stall_busy", {31'd0, ready_out}, 32'd0);
    chk("stall_deg", {16'd0, deg_out}, 32'd2);
    neigh_mode = 1;
    finish_vertex(8'd10, 1'b0);

    // Zero-degree vertex.
    lst = '{16'd0};
    put_list(8'd10, 16'd7, 16'd9, lst);
    start_vertex(8'd10);
    finish_vertex(8'd10, 1'b1);

    // Longer list: truncated at MAX_DEG when the cap is built in.
    lst = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd0};
    put_list(8'd20, 16'h111, 16'h222, lst);
    start_vertex(8'd20);
    finish_vertex(8'd20, 1'b0);

    // Address wrap at the top of the address space.
    lst = '{16'h33, 16'd0};
    put_list(8'd254, 16'h11, 16'h22, lst);
    start_vertex(8'd254);
    finish_vertex(8'd254, 1'b0);

    // Reset mid-fetch, then stale responses on both ports.
    rand_lat = 1'b1; pos_mode = 2; neigh_mode = 2;
    lst = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
    put_list(8'd40, 16'hA1, 16'hA2, lst);
    start_vertex(8'd40);
    repeat (4) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk("midrst_ready", {31'd0, ready_out}, 32'd1);
    chk("midrst_empty", {30'd0, pos_empty_out, neigh_empty_out}, 32'd3);
    chk("midrst_valid", {30'd0, pos_valid_out, neigh_valid_out}, 32'd0);
    chk("midrst_deg", {16'd0, deg_out}, 32'd0);
    inj = 1'b1;
    repeat (2) @(negedge clk);
    inj = 1'b0;
    repeat (5) @(negedge clk);
    chk("stale_empty", {30'd0, pos_empty_out, neigh_empty_out}, 32'd3);
    chk("stale_ready", {31'd0, ready_out}, 32'd1);
    chk("stale_deg", {16'd0, deg_out}, 32'd0);
    pos_mode = 2; neigh_mode = 2;
    start_vertex(8'd40);
    finish_vertex(8'd40, 1'b0);

    // Random records, random latency and random pops.
    for (int t = 0; t < 8; t++) begin
      v = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 5);
      lst.delete();
      for (int i = 0; i < n; i++) lst.push_back(16'($urandom_range(1, 16'hFFFF)));
      lst.push_back(16'd0);
      put_list(v, 16'($urandom), 16'($urandom), lst);
      pos_mode = 2; neigh_mode = 2;
      start_vertex(v);
      finish_vertex(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
